dmem_responder: RTL and testbench

- Responder end of the data-memory request interface driven by the execute stage: data_addr, data_to_memory, data_memory_we, data_memory_re.
- Services each request from one of two regions:
  - Local region: a BRAM that answers with fixed 1-cycle read latency.
  - External region: forwarded over a req/ack handshake, with a pipeline stall held until the access completes.
- Read data is presented to the memory-access stage in the cycle after the request is accepted.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder_bram.sv | 36 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types, default sizing and address-decode helper for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam int unsigned DEF_LOCAL_WORDS = 16384;
  localparam int unsigned DEF_TIMEOUT     = 1024;

  // Word index below the local size selects the on-chip BRAM.
  function automatic logic is_local(input logic [31:0] addr, input logic [31:0] words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (word_idx < words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Execute-stage data-memory request bus; master is the pipeline, slave is the responder.
interface dmem_if;

  logic [31:0] data_addr;
  logic [31:0] data_to_memory;
  logic        data_memory_we;
  logic        data_memory_re;
  logic [31:0] read_data;
  logic        stall;

  modport master (
    output data_addr, data_to_memory, data_memory_we, data_memory_re,
    input  read_data, stall
  );

  modport slave (
    input  data_addr, data_to_memory, data_memory_we, data_memory_re,
    output read_data, stall
  );

endinterface

// File: rtl/dmem_responder_bram.sv
// Single-port, read-first, synchronous-read word memory backing the local region.
module dmem_bram #(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Array write port; storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port returns the pre-write contents of the addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: local BRAM with 1-cycle loads, external region via a
// req/ack handshake that stalls the pipeline until the access completes or times out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LOCAL_WORDS = DEF_LOCAL_WORDS,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       cpu,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned AW = $clog2(LOCAL_WORDS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  dmem_state_t state_q, state_d;
  logic          ext_req_q, ext_req_d;
  logic          ext_we_q, ext_we_d;
  logic [31:0]   ext_addr_q, ext_addr_d;
  logic [31:0]   ext_wdata_q, ext_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cap_q, cap_d;
  logic [31:0]   data_q, data_d;
  logic          rd_local_q, rd_local_d;
  logic          misalign_q, misalign_d;
  logic          timeout_q, timeout_d;

  logic          req_s;
  logic          local_s;
  logic          stall_s;
  logic          bram_en_s;
  logic [31:0]   bram_rdata_s;

  assign req_s   = cpu.data_memory_we | cpu.data_memory_re;
  assign local_s = is_local(cpu.data_addr, 32'(LOCAL_WORDS));

  dmem_bram #(
    .WORDS (LOCAL_WORDS),
    .AW    (AW)
  ) u_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (bram_en_s),
    .we_i    (cpu.data_memory_we),
    .addr_i  (cpu.data_addr[AW+1:2]),
    .wdata_i (cpu.data_to_memory),
    .rdata_o (bram_rdata_s)
  );

  // Next-state, handshake and stall decode for both regions.
  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    data_d      = 32'h0000_0000;
    rd_local_d  = 1'b0;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;
    stall_s     = 1'b0;
    bram_en_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (cpu.data_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            misalign_d = misalign_q;
          end
          if (local_s) begin
            bram_en_s  = 1'b1;
            rd_local_d = cpu.data_memory_re & ~cpu.data_memory_we;
          end else begin
            stall_s     = 1'b1;
            ext_addr_d  = {cpu.data_addr[31:2], 2'b00};
            ext_wdata_d = cpu.data_to_memory;
            ext_we_d    = cpu.data_memory_we;
            ext_req_d   = 1'b1;
            cap_d       = 32'h0000_0000;
            state_d     = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        stall_s = 1'b1;
        // An ack in the final counted cycle still completes normally.
        if (ext_ack) begin
          cap_d     = ext_we_q ? 32'h0000_0000 : ext_rdata;
          ext_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cap_d     = 32'h0000_0000;
          ext_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        data_d  = cap_q;
        state_d = IDLE;
      end
      default: begin
        ext_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 32'h0000_0000;
      ext_wdata_q <= 32'h0000_0000;
      cnt_q       <= '0;
      cap_q       <= 32'h0000_0000;
      data_q      <= 32'h0000_0000;
      rd_local_q  <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
      rd_local_q  <= rd_local_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  // Local loads come straight from the BRAM output register.
  assign cpu.read_data = rd_local_q ? bram_rdata_s : data_q;
  assign cpu.stall     = rst_n & stall_s;
  assign ext_req       = ext_req_q;
  assign ext_we        = ext_we_q;
  assign ext_addr      = ext_addr_q;
  assign ext_wdata     = ext_wdata_q;
  assign misalign_err  = misalign_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a transaction-level model.
module tb_dmem_responder;

  localparam int unsigned LW = 16384;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_req, ext_we, ext_ack, misalign_err, timeout_err;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;

  dmem_if cpu_if ();

  dmem_responder #(.LOCAL_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu          (cpu_if.slave),
    .ext_req      (ext_req),
    .ext_we       (ext_we),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_ack      (ext_ack),
    .ext_rdata    (ext_rdata),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] mem_model [int unsigned];
  bit mis_model = 1'b0;
  bit to_model  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] data);
    cpu_if.data_memory_we = we;
    cpu_if.data_memory_re = re;
    cpu_if.data_addr      = addr;
    cpu_if.data_to_memory = data;
  endtask

  // One local access: no stall, result (or 0) one cycle later.
  task automatic local_access(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp;
    int unsigned w;
    w = addr >> 2;
    drive(we, re, addr, data);
    #1;
    n_cmp++;
    if (cpu_if.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL local_stall addr=%h got %b want 0", addr, cpu_if.stall);
    end
    exp = (re && !we) ? mem_model[w] : 32'h0;
    if (we) mem_model[w] = data;
    if ((we || re) && addr[1:0] != 2'b00) mis_model = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cpu_if.read_data !== exp) begin
      n_fail++;
      $display("FAIL local_read_data addr=%h got %h want %h", addr, cpu_if.read_data, exp);
    end
    n_cmp++;
    if (misalign_err !== mis_model) begin
      n_fail++;
      $display("FAIL local_misalign got %b want %b", misalign_err, mis_model);
    end
  endtask

  // One external access; ack_n = WAIT cycle carrying the ack (0 = never).
  task automatic ext_access(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] data,
                            input int ack_n, input logic [31:0] rdata, input bit late_ack);
    int stall_cnt, req_cnt, rises, exp_stall;
    bit prev, done, acked;
    logic [31:0] exp_rd;
    stall_cnt = 0; req_cnt = 0; rises = 0; prev = 1'b0; done = 1'b0;
    acked     = (ack_n != 0) && (ack_n <= int'(TO));
    exp_stall = acked ? ack_n + 2 : int'(TO) + 2;
    exp_rd    = (re && !we && acked) ? rdata : 32'h0;
    if (!acked) to_model = 1'b1;
    if (addr[1:0] != 2'b00) mis_model = 1'b1;
    drive(we, re, addr, data);
    for (int c = 0; c < 64; c++) begin
      #1;
      if (cpu_if.stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (ext_req === 1'b1) begin
        req_cnt++;
        if (!prev) rises++;
        n_cmp++;
        if (ext_addr !== {addr[31:2], 2'b00} || ext_we !== we || ext_wdata !== data) begin
          n_fail++;
          $display("FAIL ext_held got a=%h we=%b d=%h want a=%h we=%b d=%h",
                   ext_addr, ext_we, ext_wdata, {addr[31:2], 2'b00}, we, data);
        end
      end
      prev      = ext_req;
      ext_ack   = (ack_n != 0) && (stall_cnt - 2 == ack_n);
      ext_rdata = ext_ack ? rdata : $urandom;
      @(posedge clk);
      #1;
      ext_ack = 1'b0;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL ext_stall_bound got stall stuck want release within 64 cycles");
    end
    n_cmp++;
    if (stall_cnt != exp_stall || req_cnt != exp_stall - 1 || rises != 1) begin
      n_fail++;
      $display("FAIL ext_timing got stall=%0d req=%0d issues=%0d want stall=%0d req=%0d issues=1",
               stall_cnt, req_cnt, rises, exp_stall, exp_stall - 1);
    end
    n_cmp++;
    if (ext_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_done_req got %b want 0", ext_req);
    end
    if (late_ack) begin
      ext_ack   = 1'b1;
      ext_rdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    ext_ack = 1'b0;
    n_cmp++;
    if (cpu_if.read_data !== exp_rd) begin
      n_fail++;
      $display("FAIL ext_read_data got %h want %h", cpu_if.read_data, exp_rd);
    end
    n_cmp++;
    if (timeout_err !== to_model || misalign_err !== mis_model) begin
      n_fail++;
      $display("FAIL ext_flags got to=%b mis=%b want to=%b mis=%b", timeout_err, misalign_err, to_model, mis_model);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ext_ack = 1'b0;
    ext_rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();
    n_cmp++;
    if (cpu_if.read_data !== 32'h0 || cpu_if.stall !== 1'b0 || ext_req !== 1'b0 || ext_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%h st=%b req=%b we=%b want all 0", cpu_if.read_data, cpu_if.stall, ext_req, ext_we);
    end
    n_cmp++;
    if (ext_addr !== 32'h0 || ext_wdata !== 32'h0 || misalign_err !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs got a=%h d=%h mis=%b to=%b want all 0", ext_addr, ext_wdata, misalign_err, timeout_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_local();
    local_access(1'b1, 1'b0, 32'h100, 32'hCAFE_BABE);
    local_access(1'b0, 1'b1, 32'h100, 32'h0);
    local_access(1'b0, 1'b0, 32'h100, 32'h0);
  endtask

  task automatic test_local_random();
    logic [31:0] pool [16];
    for (int i = 0; i < 16; i++) begin
      pool[i] = $urandom_range(0, LW - 1) << 2;
      local_access(1'b1, 1'b0, pool[i], $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      local_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], $urandom);
    end
  endtask

  task automatic test_ext_load();
    ext_access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 3, 32'h1234_5678, 1'b0);
    local_access(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_ext_store();
    ext_access(1'b1, 1'b0, 32'h0002_0004, 32'hA5A5_A5A5, 1, $urandom, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ext_req !== 1'b0 || cpu_if.read_data !== 32'h0) begin
        n_fail++;
        $display("FAIL store_no_reissue got req=%b rd=%h want 0/0", ext_req, cpu_if.read_data);
      end
    end
  endtask

  task automatic test_timeout();
    ext_access(1'b0, 1'b1, 32'h0004_0000, 32'h0, 0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    ext_ack = 1'b1;
    ext_rdata = 32'h5555_AAAA;
    step();
    ext_ack = 1'b0;
    n_cmp++;
    if (cpu_if.read_data !== 32'h0 || cpu_if.stall !== 1'b0 || timeout_err !== 1'b1 || ext_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack got rd=%h st=%b to=%b req=%b want 0/0/1/0", cpu_if.read_data, cpu_if.stall, timeout_err, ext_req);
    end
  endtask

  task automatic test_misalign_dual();
    local_access(1'b1, 1'b1, 32'h102, 32'h11);
    local_access(1'b0, 1'b1, 32'h100, 32'h0);
  endtask

  task automatic test_back_to_back();
    bit we, re;
    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (!we && !re) re = 1'b1;
      ext_access(we, re, 32'h0001_0000 + ($urandom_range(0, 16383) << 2), $urandom,
                 $urandom_range(1, 6), $urandom, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b0, 1'b1, 32'h0003_0000, 32'h0);
    step();
    step();
    n_cmp++;
    if (ext_req !== 1'b1 || cpu_if.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_wait got req=%b st=%b want 1/1", ext_req, cpu_if.stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ext_req !== 1'b0 || cpu_if.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait got req=%b st=%b want 0/0", ext_req, cpu_if.stall);
    end
    ext_ack = 1'b1;
    repeat (2) step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step();
    ext_ack = 1'b0;
    mis_model = 1'b0;
    to_model  = 1'b0;
    n_cmp++;
    if (misalign_err !== 1'b0 || timeout_err !== 1'b0 || ext_req !== 1'b0 || cpu_if.read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset got mis=%b to=%b req=%b rd=%h want 0/0/0/0", misalign_err, timeout_err, ext_req, cpu_if.read_data);
    end
    ext_access(1'b0, 1'b1, 32'h0003_0000, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
    local_access(1'b0, 1'b1, 32'h100, 32'h0);
  endtask

  initial begin
    test_reset();
    test_local();
    test_local_random();
    test_ext_load();
    test_ext_store();
    test_timeout();
    test_misalign_dual();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
